// File: rtl/fir_stim_pkg.sv
// Shared encodings and defaults for the FIR stimulus generator and its LFSR.
package fir_stim_pkg;

  typedef enum logic [1:0] {
    STIM_IMPULSE = 2'd0,
    STIM_STEP    = 2'd1,
    STIM_RAMP    = 2'd2,
    STIM_LFSR    = 2'd3
  } stim_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } stim_state_t;

  localparam logic [31:0] STIM_POLY_DEF = 32'h8020_0003;
  localparam logic [31:0] STIM_SEED_DEF = 32'h0000_0001;

  // One Galois step: shift right, fold the feedback mask in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] poly);
    lfsr_next = (s >> 1) ^ (s[0] ? poly : 32'd0);
  endfunction

endpackage

// File: rtl/fir_stim_lfsr.sv
// 32-bit Galois LFSR; load restores the seed, adv takes one step.
module fir_stim_lfsr
  import fir_stim_pkg::*;
#(
  parameter logic [31:0] SEED = STIM_SEED_DEF,
  parameter logic [31:0] POLY = STIM_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] state
);

  // An all-zero state would lock up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_EFF;
    end else if (load) begin
      r_state <= SEED_EFF;
    end else if (adv) begin
      r_state <= lfsr_next(r_state, POLY);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/fir_stim_gen.sv
// Test-signal source for the FIR sockets: periodic ready strobe plus a
// registered impulse/step/ramp/LFSR sample, with a start/busy/done handshake.
module fir_stim_gen
  import fir_stim_pkg::*;
#(
  parameter int          WIDTH = 24,
  parameter logic [31:0] SEED  = STIM_SEED_DEF,
  parameter logic [31:0] POLY  = STIM_POLY_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [15:0]             num_samples,
  input  logic [7:0]              period,
  output logic signed [WIDTH-1:0] input_sig,
  output logic                    ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] AMP = {1'b0, {(WIDTH-1){1'b1}}};

  stim_state_t             r_state;
  stim_mode_t              r_mode;
  logic [15:0]             r_n;
  logic [7:0]              r_p;
  logic [7:0]              r_pcnt;
  logic [15:0]             r_sent;
  logic signed [WIDTH-1:0] r_sig;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_load;
  logic                    w_emit;
  logic [31:0]             w_lfsr_state;
  logic [31:0]             w_sent32;
  logic signed [WIDTH-1:0] w_sample;
  logic                    w_unused;

  // A sample goes out on period count 0 unless the run is being aborted.
  assign w_load   = (r_state == ST_IDLE) && start;
  assign w_emit   = (r_state == ST_RUN) && (r_pcnt == 8'd0) && !abort;
  assign w_sent32 = 32'(r_sent);
  assign w_unused = ^{w_lfsr_state, w_sent32};

  fir_stim_lfsr #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .adv   (w_emit),
    .state (w_lfsr_state)
  );

  always_comb begin
    w_sample = '0;
    case (r_mode)
      STIM_IMPULSE: w_sample = (r_sent == 16'd0) ? AMP : '0;
      STIM_STEP:    w_sample = AMP;
      STIM_RAMP:    w_sample = $signed(w_sent32[WIDTH-1:0]);
      STIM_LFSR:    w_sample = $signed(w_lfsr_state[WIDTH-1:0]);
      default:      w_sample = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= STIM_IMPULSE;
      r_n     <= 16'd0;
      r_p     <= 8'd1;
      r_pcnt  <= 8'd0;
      r_sent  <= 16'd0;
      r_sig   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode  <= stim_mode_t'(mode);
            r_n     <= num_samples;
            r_p     <= (period == 8'd0) ? 8'd1 : period;
            r_pcnt  <= 8'd0;
            r_sent  <= 16'd0;
            r_busy  <= 1'b1;
            r_state <= (num_samples == 16'd0) ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            if (w_emit) begin
              r_sig   <= w_sample;
              r_ready <= 1'b1;
              r_sent  <= r_sent + 16'd1;
              if (r_sent + 16'd1 == r_n) begin
                r_state <= ST_FIN;
              end
            end
            r_pcnt <= (r_pcnt == r_p - 8'd1) ? 8'd0 : r_pcnt + 8'd1;
          end
        end
        // busy stays up through FIN and drops together with the done pulse.
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign input_sig = r_sig;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/fir_stim_gen.md
# fir_stim_gen

Sample-stream source for the FIR filter sockets: generates a signed `WIDTH`-bit test signal and the one-cycle `ready` strobe that the FIR filters consume on their `input_sig`/`ready` inputs. It sits upstream of the direct-form and separable FIR sockets in bench and on-chip self-test builds. Start/busy/done handshake toward the controller; programmable strobe period, sample count and waveform.

## Interface
- `WIDTH`, 24: sample width, 2..32.
- `SEED`, 32'h0000_0001: LFSR seed; 0 is replaced by 1.
- `POLY`, 32'h8020_0003: Galois LFSR feedback mask.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch request; sampled only in IDLE.
- `abort` in 1: stop the run; effective in RUN only.
- `mode` in 2: waveform. 0 impulse, 1 step, 2 ramp, 3 LFSR.
- `num_samples` in 16: samples per run, N.
- `period` in 8: cycles between strobes, P; 0 treated as 1.
- `input_sig` out signed `WIDTH`: current sample. Registered, held between strobes.
- `ready` out 1: one-cycle strobe marking a new sample.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse at normal run completion.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, with `start`=1: latch `mode`, N and P, and reload the LFSR with `SEED`.
  - N=0: go to FIN, no strobe.
  - N>0: go to RUN.
- RUN: a period counter runs 0..P-1. At count 0:
  - emit one sample, assert `ready`, increment the sent counter;
  - when the sent counter reaches N, go to FIN.
- FIN: pulse `done` for 1 cycle, then return to IDLE.
- Sample n (0-based) by mode:
  - Impulse: n=0 gives AMP = 2^(WIDTH-1)-1; all later samples are 0.
  - Step: AMP on every sample.
  - Ramp: n mod 2^WIDTH, two's complement; 2^(WIDTH-1)-1 wraps to -2^(WIDTH-1).
  - LFSR: low `WIDTH` bits of the state. The state advances after each emission: s' = (s>>1) ^ (s[0] ? POLY : 0).
- `abort` in RUN: return to IDLE at the next edge. `ready` is 0 from that edge; no `done`; `input_sig` is held.
- `abort` outside RUN is ignored.
- `start` while busy or in FIN is ignored.
- `start` and `abort` together in IDLE: start wins.
- Latched configuration is immune to input changes mid-run.

## Timing
- Reset values:
  - outputs: `input_sig`=0, `ready`=0, `busy`=0, `done`=0;
  - internal: state IDLE, LFSR = `SEED`, counters 0.
- Reset asserted mid-run returns to these values immediately; no `done` is produced.
- With `start` sampled at edge k and N>0:
  - `busy` rises at edge k;
  - the first `ready` and first sample appear at edge k+1;
  - strobe i appears at edge k+1+i·P.
- `ready` is high exactly 1 cycle per sample and never in consecutive cycles unless P=1. With P=1 it is continuous for N cycles.
- Completion after the last strobe (edge k+1+(N-1)·P):
  - `busy` falls at the next edge;
  - `done` is high for that one cycle.
- N=0: `busy` is high for 1 cycle and `done` rises at edge k+1.
- A new `start` is accepted in the cycle `done` is high, i.e. in IDLE after FIN.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package `fir_stim_pkg`:
  - mode encodings `STIM_IMPULSE`/`STIM_STEP`/`STIM_RAMP`/`STIM_LFSR`;
  - FSM state encodings;
  - default `POLY`/`SEED` constants.
- Sub-module `fir_stim_lfsr`:
  - 32-bit Galois LFSR with `load` (seed) and `adv` inputs;
  - `state` output;
  - same `clk`/`rst_n`.
- Everything else stays in the top module: FSM, period and sent counters, waveform mux.

## Test plan
- Reset: `rst_n`=0 mid-run with P=3, N=10 -> all outputs 0 at once; after release, IDLE with no `done`.
- Impulse: mode 0, N=4, P=2, WIDTH=24 -> `ready` at k+1, k+3, k+5, k+7; samples 8388607, 0, 0, 0; `done` at k+8.
- Ramp wrap: mode 2, WIDTH=4, N=10, P=1 -> samples 0..7, then -8, -7; `ready` high 10 cycles; then `done`.
- LFSR: mode 3, SEED=1, N=3, P=1 -> samples 0x000001, 0x200003, 0x300002.
- Abort and ignored start: abort after the 2nd of N=5 strobes -> no further `ready`, no `done`, `busy` low next cycle. A `start` pulse during RUN has no effect on N, P or timing.
- Edge configurations:
  - N=0 -> `done` one cycle after `start`, no `ready`;
  - P=0 -> behaves as P=1.
